maze_memory: RTL and testbench

Maze storage stage directly upstream and downstream of the wall-follower solver. Holds a square wall bitmap of 2^maze_width x 2^maze_width cells loaded one row per beat from a host stream. It serves the solver's synchronous read (`maze_oe`) and mark (`maze_we`) accesses. Once the solver raises `done`, it streams the visited-cell plane back out row by row.

---
 rtl/maze_memory.sv | 125 ++++++++++++
 tb/tb_maze_memory.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_memory.sv
// maze_memory: wall/visited bitmap store between a host loader, the
// wall-follower solver and a row-by-row visited-plane dump stream.
module maze_memory #(
  parameter int maze_width = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [(1<<maze_width)-1:0]  load_data,
  input  logic [maze_width-1:0]       row,
  input  logic [maze_width-1:0]       col,
  input  logic                        maze_oe,
  input  logic                        maze_we,
  output logic                        maze_in,
  output logic                        solver_run,
  input  logic                        done,
  output logic                        dump_valid,
  input  logic                        dump_ready,
  output logic [maze_width-1:0]       dump_row,
  output logic [(1<<maze_width)-1:0]  dump_data,
  output logic                        dump_last
);

  localparam int DEPTH = 1 << maze_width;
  localparam logic [maze_width-1:0] LAST_ROW = '1;

  typedef enum logic [2:0] {IDLE, LOAD, SERVE, DUMP, FINISHED} state_e;

  state_e                  state_q, state_d;
  logic [maze_width-1:0]   cnt_q, cnt_d;
  logic                    maze_in_q, maze_in_d;
  logic                    load_ready_q, load_ready_d;
  logic                    solver_run_q, solver_run_d;
  logic                    dump_valid_q, dump_valid_d;
  logic                    load_beat;
  logic                    mark;

  logic [DEPTH-1:0]        wall_mem    [DEPTH];
  logic [DEPTH-1:0]        visited_mem [DEPTH];

  // Next-state, row counter, read-data and storage-strobe decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    maze_in_d = maze_in_q;
    load_beat = 1'b0;
    mark      = 1'b0;
    unique case (state_q)
      IDLE, FINISHED: begin
        if (load_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          load_beat = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_ROW) state_d = SERVE;
        end
      end
      SERVE: begin
        if (maze_oe) maze_in_d = wall_mem[row][col];
        mark = maze_we;
        if (done) begin
          state_d = DUMP;
          cnt_d   = '0;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ROW) state_d = FINISHED;
        end
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == LOAD);
    solver_run_d = (state_d == SERVE);
    dump_valid_d = (state_d == DUMP);
  end

  // Control state and registered handshake outputs; async reset to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      maze_in_q    <= 1'b0;
      load_ready_q <= 1'b0;
      solver_run_q <= 1'b0;
      dump_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      maze_in_q    <= maze_in_d;
      load_ready_q <= load_ready_d;
      solver_run_q <= solver_run_d;
      dump_valid_q <= dump_valid_d;
    end
  end

  // Wall/visited storage: row writes during load, single-bit marks in SERVE.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; a load rewrites every row of both planes.
    if (load_beat) begin
      wall_mem[cnt_q]    <= load_data;
      visited_mem[cnt_q] <= '0;
    end else if (mark) begin
      visited_mem[row][col] <= 1'b1;
    end
  end

  assign load_ready = load_ready_q;
  assign solver_run = solver_run_q;
  assign maze_in    = maze_in_q;
  assign dump_valid = dump_valid_q;
  assign dump_row   = dump_valid_q ? cnt_q : '0;
  assign dump_last  = dump_valid_q && (cnt_q == LAST_ROW);
  assign dump_data  = dump_valid_q ? visited_mem[cnt_q] : '0;

endmodule

// File: tb/tb_maze_memory.sv
// tb_maze_memory: scoreboard bench for maze_memory (maze_width = 6).
module tb_maze_memory;

  localparam int W     = 6;
  localparam int DEPTH = 1 << W;

  typedef struct packed {
    logic [W-1:0]     row;
    logic [DEPTH-1:0] data;
    logic             last;
  } dump_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_start, load_valid, load_ready;
  logic [DEPTH-1:0] load_data;
  logic [W-1:0]     row, col;
  logic             maze_oe, maze_we, maze_in, solver_run, done;
  logic             dump_valid, dump_ready, dump_last;
  logic [W-1:0]     dump_row;
  logic [DEPTH-1:0] dump_data;

  int checks = 0;
  int errors = 0;

  logic [DEPTH-1:0] tb_wall [DEPTH];
  logic [DEPTH-1:0] tb_vis  [DEPTH];
  bit               rd_q [$];
  dump_t            dump_q [$];
  logic             rd_pend = 1'b0;
  logic             last_rd = 1'b0;

  maze_memory #(.maze_width(W)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .solver_run(solver_run), .done(done),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_row(dump_row),
    .dump_data(dump_data), .dump_last(dump_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: note accepted solver reads at the edge.
  always @(posedge clk) rd_pend <= solver_run && maze_oe && !rst;

  // Monitor: compare read data and presented dump rows against the queues.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL maze_in_extra read result with nothing expected");
      end else begin
        check("maze_in", maze_in, rd_q.pop_front());
      end
    end
    if (dump_valid) begin
      if (dump_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dump_extra row %0d presented with nothing expected", dump_row);
      end else begin
        check("dump_row",  dump_row,  dump_q[0].row);
        check("dump_data", dump_data, dump_q[0].data);
        check("dump_last", dump_last, dump_q[0].last);
        if (dump_ready) void'(dump_q.pop_front());
      end
    end
  end

  task automatic set_walls(input logic [63:0] row11);
    for (int r = 0; r < DEPTH; r++)
      tb_wall[r] = {32'(r) * 32'h0101_0101, ~(32'(r) * 32'h00FF_0F01)};
    tb_wall[3]  = 64'h0000_0000_0000_0010;
    tb_wall[5]  = 64'h0000_0000_0000_0080;
    tb_wall[11] = row11;
  endtask

  // Full load; optional 3-cycle load_valid gap after beat 10. done pulses mid-load (ignored).
  task automatic do_load(input bit gap);
    int beat = 0, stall = 0, hi = 0, cyc = 0;
    logic rdy;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    while (beat < DEPTH && cyc < 300) begin
      load_valid = !(gap && beat == 11 && stall < 3);
      if (!load_valid) stall++;
      load_data = tb_wall[beat];
      done      = (beat == 30);
      @(negedge clk);
      rdy = load_ready;
      if (load_ready) hi++;
      @(posedge clk); #1;
      if (load_valid && rdy) beat++;
      cyc++;
    end
    load_valid = 1'b0;
    done       = 1'b0;
    for (int r = 0; r < DEPTH; r++) tb_vis[r] = '0;
    @(negedge clk);
    check("load_ready_cycles", hi, gap ? 67 : 64);
    check("load_ready_fall", load_ready, 1'b0);
    check("solver_run_rise", solver_run, 1'b1);
  endtask

  task automatic access(input int r, input int c, input bit oe, input bit we);
    row = W'(r); col = W'(c); maze_oe = oe; maze_we = we;
    if (oe) begin
      rd_q.push_back(tb_wall[r][c]);
      last_rd = tb_wall[r][c];
    end
    if (we) tb_vis[r][c] = 1'b1;
    @(posedge clk); #1 maze_oe = 1'b0; maze_we = 1'b0;
  endtask

  task automatic do_done();
    dump_t e;
    for (int r = 0; r < DEPTH; r++) begin
      e.row = W'(r); e.data = tb_vis[r]; e.last = (r == DEPTH - 1);
      dump_q.push_back(e);
    end
    done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    check("done_solver_run_low", solver_run, 1'b0);
    check("done_dump_valid_high", dump_valid, 1'b1);
  endtask

  task automatic check_finished(input string tag);
    @(negedge clk);
    check({tag, "_rows_left"}, dump_q.size(), 0);
    check({tag, "_dump_valid"}, dump_valid, 1'b0);
    check({tag, "_load_ready"}, load_ready, 1'b0);
    check({tag, "_solver_run"}, solver_run, 1'b0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; load_start = 1'b1; load_valid = 1'b0; load_data = '0;
    row = 6'd3; col = 6'd4; maze_oe = 1'b0; maze_we = 1'b1; done = 1'b0; dump_ready = 1'b0;
    #1;
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_solver_run", solver_run, 1'b0);
    check("rst_dump_valid", dump_valid, 1'b0);
    check("rst_maze_in", maze_in, 1'b0);
    check("rst_dump_row", dump_row, 0);
    repeat (3) @(posedge clk);
    #1 load_start = 1'b0; maze_we = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_rst_load_ready", load_ready, 1'b0);

    // Maze 1: full load, reads, ignored load_start, marks, stalled dump.
    set_walls(64'hDEAD_BEEF_0123_4567);
    do_load(1'b0);
    access(5, 7, 1, 0);
    access(5, 6, 1, 0);
    access(11, 0, 1, 0);
    access(11, 63, 1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("maze_in_hold", maze_in, last_rd);
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    @(negedge clk);
    check("serve_ignores_load_start_ready", load_ready, 1'b0);
    check("serve_ignores_load_start_run", solver_run, 1'b1);
    @(posedge clk); #1;
    access(3, 4, 1, 1);
    access(3, 63, 0, 1);
    do_done();
    cyc = 0;
    while (dump_q.size() > 0 && cyc < 400) begin
      @(posedge clk); #1;
      dump_ready = ~dump_ready;
      if (cyc == 5) begin
        row = 6'd63; col = 6'd0; maze_oe = 1'b1; maze_we = 1'b1;
      end else begin
        maze_oe = 1'b0; maze_we = 1'b0;
      end
      cyc++;
    end
    dump_ready = 1'b0;
    check_finished("dump1");
    check("dump_ignores_maze_oe", maze_in, last_rd);

    // Maze 2: load with backpressure from FINISHED, then reset mid-dump at row 20.
    set_walls(64'h0F0F_0000_FFFF_8001);
    @(posedge clk); #1;
    do_load(1'b1);
    access(11, 0, 1, 0);
    access(11, 1, 1, 0);
    access(11, 15, 1, 0);
    access(11, 56, 1, 0);
    access(11, 63, 1, 0);
    access(12, 34, 1, 0);
    access(12, 32, 1, 0);
    access(20, 5, 0, 1);
    dump_ready = 1'b1;
    do_done();
    repeat (20) @(posedge clk);
    #1 dump_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_rows_taken", dump_q.size(), DEPTH - 20);
    check("midrst_dump_valid", dump_valid, 1'b0);
    check("midrst_dump_last", dump_last, 1'b0);
    check("midrst_solver_run", solver_run, 1'b0);
    check("midrst_load_ready", load_ready, 1'b0);
    check("midrst_maze_in", maze_in, 1'b0);
    dump_q.delete();
    @(negedge clk); #1 rst = 1'b0;

    // Maze 3: reload from IDLE; visited plane must come back all zero.
    do_load(1'b0);
    dump_ready = 1'b1;
    do_done();
    cyc = 0;
    while (dump_q.size() > 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    dump_ready = 1'b0;
    check_finished("dump3");
    check("reads_all_returned", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
